imem_refill_responder: RTL and testbench

Memory-side responder for instruction-cache line fills. When the fetch stage's instruction cache misses, it issues a line-fill request. This block accepts the request, models a fixed memory access latency, and returns the line as a sequence of 32-bit beats under a valid/ready handshake. It holds the instruction memory array, plus a load port used to preload programs.

---
 rtl/imem_refill_responder.sv | 104 ++++++++++
 tb/tb_imem_refill_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_refill_responder.sv
// imem_refill_responder: instruction-memory line-fill responder with fixed latency and beat handshake.
// Define REFILL_CRITICAL_WORD_FIRST_EN to return the critical word first and wrap around the line.
module imem_refill_responder #(
  parameter int WORDS_PER_LINE = 4,
  parameter int MEM_LATENCY = 3,
  parameter int MEM_DEPTH = 1024,
  localparam int OW = $clog2(WORDS_PER_LINE),
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int CW = $clog2(MEM_LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [31:0]   req_addr,
  output logic          req_ready,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_data,
  output logic [OW-1:0] resp_word_idx,
  output logic          resp_last,
  input  logic          ld_en,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_data
);
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [AW-OW-1:0] line_q, line_sel;
  logic [OW-1:0] beat_q, beat_sel, off_sel;
  logic load, done;
  logic [31:0] mem [MEM_DEPTH];
  assign line_sel = (state == IDLE) ? req_addr[AW+1:OW+2] : line_q;
  assign beat_sel = (state == BURST) ? beat_q + OW'(1) : '0;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  logic [OW-1:0] crit_q;
  logic unused;
  assign off_sel = ((state == IDLE) ? req_addr[OW+1:2] : crit_q) + beat_sel;
  assign unused = ^{req_addr[31:AW+2], req_addr[1:0], ld_addr[31:AW+2], ld_addr[1:0]};
  always_ff @(posedge clk)
    if (rst) crit_q <= '0;
    else if (state == IDLE && req_valid) crit_q <= req_addr[OW+1:2];
`else
  logic unused;
  assign off_sel = beat_sel;
  assign unused = ^{req_addr[31:AW+2], req_addr[OW+1:0], ld_addr[31:AW+2], ld_addr[1:0]};
`endif
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    load = 1'b0;
    done = 1'b0;
    req_ready = (state == IDLE);
    case (state)
      IDLE:
        if (req_valid) begin
          cnt_n = CW'(MEM_LATENCY - 1);
          if (MEM_LATENCY == 1) begin
            load = 1'b1;
            state_n = BURST;
          end else state_n = WAIT;
        end
      WAIT:
        if (cnt <= CW'(1)) begin
          load = 1'b1;
          cnt_n = '0;
          state_n = BURST;
        end else cnt_n = cnt - CW'(1);
      BURST:
        if (resp_valid && resp_ready) begin
          done = resp_last;
          load = !resp_last;
          if (resp_last) state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      line_q <= '0;
      beat_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && req_valid) line_q <= req_addr[AW+1:OW+2];
      if (load) beat_q <= beat_sel;
    end
  // Beats sample the array before any same-edge load-port write lands.
  always_ff @(posedge clk)
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data <= '0;
      resp_word_idx <= '0;
      resp_last <= 1'b0;
    end else if (load) begin
      resp_valid <= 1'b1;
      resp_data <= mem[{line_sel, off_sel}];
      resp_word_idx <= off_sel;
      resp_last <= (beat_sel == OW'(WORDS_PER_LINE - 1));
    end else if (done) resp_valid <= 1'b0;
  always_ff @(posedge clk)
    if (ld_en) mem[ld_addr[AW+1:2]] <= ld_data;
endmodule

// File: tb/tb_imem_refill_responder.sv
// tb_imem_refill_responder: vector table, corner sequences and randomized fills against a line-level model.
module tb_imem_refill_responder;
  localparam int L = 3;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b1, resp_last, ld_en = 1'b0;
  logic [31:0] req_addr = '0, resp_data, ld_addr = '0, ld_data = '0;
  logic [1:0] resp_word_idx;
  logic [31:0] mdl [1024];
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [31:0] addr;
    logic [3:0][31:0] d;
    logic [3:0][1:0] ix;
    int sb;
    int sn;
    bit poke;
  } vec_t;
  vec_t tv[6];

  imem_refill_responder dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_word_idx(resp_word_idx), .resp_last(resp_last),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d0, d1, d2, d3,
                              input int i0, i1, i2, i3, input int sb, sn, input bit pk);
    vec_t v;
    v.addr = a;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.ix[0] = 2'(i0); v.ix[1] = 2'(i1); v.ix[2] = 2'(i2); v.ix[3] = 2'(i3);
    v.sb = sb; v.sn = sn; v.poke = pk;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = v.addr; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("accepted_req_ready", req_ready, 0);
    for (int i = 0; i < L - 1; i++) begin
      chk("wait_resp_valid", resp_valid, 0);
      if (v.poke && i == 0) begin req_valid = 1'b1; req_addr = 32'h40; end
      @(negedge clk);
      req_valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (k == v.sb)
        for (int s = 0; s < v.sn; s++) begin
          resp_ready = 1'b0;
          chk("stall_valid", resp_valid, 1);
          chk("stall_data", resp_data, v.d[k]);
          chk("stall_idx", resp_word_idx, v.ix[k]);
          @(negedge clk);
        end
      resp_ready = 1'b1;
      if (v.poke && k == 1) begin req_valid = 1'b1; req_addr = 32'h40; end
      chk("beat_valid", resp_valid, 1);
      chk("beat_data", resp_data, v.d[k]);
      chk("beat_idx", resp_word_idx, v.ix[k]);
      chk("beat_last", resp_last, k == 3);
      chk("beat_req_ready", req_ready, 0);
      @(negedge clk);
      req_valid = 1'b0;
    end
    chk("done_req_ready", req_ready, 1);
    chk("done_resp_valid", resp_valid, 0);
    if (v.poke)
      for (int i = 0; i < 6; i++) begin
        chk("no_second_burst", resp_valid, 0);
        @(negedge clk);
      end
  endtask

  task automatic rand_fill();
    logic [31:0] a, d, ed[4];
    logic [1:0] ei[4];
    int unsigned wi, base, crit, off;
    int lat, k, guard;
    repeat ($urandom_range(0, 3)) begin
      a = $urandom; d = $urandom;
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      mdl[a[11:2]] = d;
      @(negedge clk);
    end
    ld_en = 1'b0;
    a = $urandom;
    wi = (a >> 2) % 1024;
    base = wi - wi % 4;
    crit = wi % 4;
    for (int j = 0; j < 4; j++) begin
      off = CWF ? (crit + j) % 4 : j;
      ed[j] = mdl[base + off];
      ei[j] = 2'(off);
    end
    chk("rand_idle_ready", req_ready, 1);
    req_valid = 1'b1; req_addr = a;
    @(negedge clk);
    lat = 1;
    while (!resp_valid && lat < 50) begin
      req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
      @(negedge clk);
      lat++;
    end
    chk("rand_latency", lat, L);
    k = 0; guard = 0;
    while (k < 4 && guard < 200) begin
      resp_ready = 1'($urandom_range(0, 1));
      req_valid = 1'($urandom_range(0, 1)); req_addr = $urandom;
      chk("rand_valid", resp_valid, 1);
      chk("rand_data", resp_data, ed[k]);
      chk("rand_idx", resp_word_idx, ei[k]);
      chk("rand_last", resp_last, k == 3);
      if (resp_ready) k++;
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    chk("rand_beats_done", k, 4);
    chk("rand_end_ready", req_ready, 1);
    chk("rand_end_valid", resp_valid, 0);
  endtask

  initial begin
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    tv[0] = mk(32'h14, 32'h1005, 32'h1006, 32'h1007, 32'h1004, 1, 2, 3, 0, -1, 0, 0);
    tv[2] = mk(32'h2C, 32'h100B, 32'h1008, 32'h1009, 32'h100A, 3, 0, 1, 2, -1, 0, 0);
    tv[3] = mk(32'h3F, 32'h100F, 32'h100C, 32'h100D, 32'h100E, 3, 0, 1, 2, -1, 0, 0);
`else
    tv[0] = mk(32'h14, 32'h1004, 32'h1005, 32'h1006, 32'h1007, 0, 1, 2, 3, -1, 0, 0);
    tv[2] = mk(32'h2C, 32'h1008, 32'h1009, 32'h100A, 32'h100B, 0, 1, 2, 3, -1, 0, 0);
    tv[3] = mk(32'h3F, 32'h100C, 32'h100D, 32'h100E, 32'h100F, 0, 1, 2, 3, -1, 0, 0);
`endif
    tv[1] = mk(32'h1000, 32'h1000, 32'h1001, 32'h1002, 32'h1003, 0, 1, 2, 3, -1, 0, 0);
    tv[4] = tv[0]; tv[4].sb = 1; tv[4].sn = 2;
    tv[5] = tv[0]; tv[5].poke = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_idx", resp_word_idx, 0);
    chk("rst_resp_last", resp_last, 0);
    for (int i = 0; i < 1024; i++) begin
      ld_en = 1'b1; ld_addr = 32'(i) << 2;
      ld_data = (i < 16) ? 32'h1000 + 32'(i) : $urandom;
      mdl[i] = ld_data;
      @(negedge clk);
    end
    ld_en = 1'b0;
    for (int i = 0; i < 6; i++) run_vec(tv[i]);
    // Abort a fill with a one-cycle reset while beat 1 is on the bus.
    req_valid = 1'b1; req_addr = 32'h14;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (L) @(negedge clk);
    chk("pre_rst_valid", resp_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_resp_data", resp_data, 0);
    chk("midrst_resp_idx", resp_word_idx, 0);
    chk("midrst_resp_last", resp_last, 0);
    run_vec(mk(32'h0, 32'h1000, 32'h1001, 32'h1002, 32'h1003, 0, 1, 2, 3, -1, 0, 0));
    // Overwrite word 6 on the same edge that registers the offset-2 beat.
    req_valid = 1'b1; req_addr = 32'h14;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (L - 1) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      if (k == (CWF ? 0 : 1)) begin ld_en = 1'b1; ld_addr = 32'h18; ld_data = 32'hDEADBEEF; end
      chk("conflict_data", resp_data, tv[0].d[k]);
      @(negedge clk);
      ld_en = 1'b0;
    end
    mdl[6] = 32'hDEADBEEF;
`ifdef REFILL_CRITICAL_WORD_FIRST_EN
    run_vec(mk(32'h14, 32'h1005, 32'hDEADBEEF, 32'h1007, 32'h1004, 1, 2, 3, 0, -1, 0, 0));
`else
    run_vec(mk(32'h14, 32'h1004, 32'h1005, 32'hDEADBEEF, 32'h1007, 0, 1, 2, 3, -1, 0, 0));
`endif
    repeat (40) rand_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
